// File: rtl/inst_mem_responder.sv
// ---------------------------------------------------------------------------
// inst_mem_responder
//   Instruction-side memory responder for the fetch front end. A fetch is
//   accepted in IDLE when request_i is high and flush_i is low; the word is
//   returned Latency edges later (counting the accept edge as edge 1) with a
//   one-cycle dataOk_o pulse. flush_i cancels an in-flight fetch and blocks
//   acceptance on the same edge. A preload write port fills the RAM.
//
// Parameters
//   Depth    number of 32-bit words (power of two, >= 4)
//   Latency  accept-to-response latency in edges (1..16)
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   request_i    fetch request (level)
//   instAddr_i   fetch byte address, sampled on the accept edge
//   flush_i      redirect flush, highest priority
//   memWe_i      preload write enable
//   memWAddr_i   preload byte address (word index = [31:2])
//   memWData_i   preload data
//   dataOk_o     one-cycle response strobe
//   inst_o       returned instruction, holds between responses
//   busy_o       high while a fetch waits (WAIT state)
//   misalign_o   misaligned-fetch response flag (INST_MEM_MISALIGN_CHK_EN)
//
// Configuration macro: INST_MEM_MISALIGN_CHK_EN
//   Defined: requests with instAddr_i[1:0] != 0 respond with inst_o = 0 and
//   misalign_o = 1 at normal latency, without reading the RAM.
//   Undefined: misalign_o is absent and instAddr_i[1:0] is ignored.
// ---------------------------------------------------------------------------
module inst_mem_responder #(
  parameter int unsigned Depth   = 1024,
  parameter int unsigned Latency = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        request_i,
  input  logic [31:0] instAddr_i,
  input  logic        flush_i,
  input  logic        memWe_i,
  input  logic [31:0] memWAddr_i,
  input  logic [31:0] memWData_i,
  output logic        dataOk_o,
  output logic [31:0] inst_o,
  output logic        busy_o
`ifdef INST_MEM_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int unsigned AW       = $clog2(Depth);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [3:0]  CNT_INIT = (Latency > 1) ? 4'(Latency - 2) : 4'd0;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  logic [31:0] r_mem [Depth];

  state_t      r_state;
  logic [31:0] r_addr_q;
  logic [3:0]  r_cnt;
  logic        r_data_ok;
  logic [31:0] r_inst;
  logic        r_busy;

  logic        w_accept;
  logic        w_respond;
  logic [31:0] w_rd_addr;
  logic        w_rd_inrange;
  logic [31:0] w_rd_word;
  logic        w_wr_inrange;
  logic        w_rd_mis;
  logic        w_unused;

`ifdef INST_MEM_MISALIGN_CHK_EN
  logic        r_mis_q;
  logic        r_misalign;
`endif

  // The read address is the live request address when responding on the
  // accept edge (Latency = 1), otherwise the latched one.
  always_comb begin
    w_accept     = (r_state == S_IDLE) && request_i && !flush_i;
    w_respond    = !flush_i &&
                   (((r_state == S_WAIT) && (r_cnt == 4'd0)) ||
                    ((Latency == 1) && w_accept));
    w_rd_addr    = (r_state == S_IDLE) ? instAddr_i : r_addr_q;
    w_rd_inrange = (w_rd_addr[31:AW+2] == '0);
    w_rd_word    = w_rd_inrange ? r_mem[w_rd_addr[AW+1:2]] : NOP_WORD;
    w_wr_inrange = (memWAddr_i[31:AW+2] == '0);
`ifdef INST_MEM_MISALIGN_CHK_EN
    w_rd_mis     = (r_state == S_IDLE) ? (instAddr_i[1:0] != 2'b00) : r_mis_q;
    w_unused     = ^{memWAddr_i[1:0], r_addr_q[1:0]};
`else
    w_rd_mis     = 1'b0;
    w_unused     = ^{memWAddr_i[1:0], r_addr_q[1:0], instAddr_i[1:0], w_rd_mis};
`endif
  end

  // Preload port; not reset. Reads sample r_mem before this edge's write,
  // so a same-edge read/write of one word returns the old data.
  always_ff @(posedge clk) begin
    if (memWe_i && w_wr_inrange) begin
      r_mem[memWAddr_i[AW+1:2]] <= memWData_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_addr_q  <= '0;
      r_cnt     <= '0;
      r_data_ok <= 1'b0;
      r_inst    <= '0;
      r_busy    <= 1'b0;
`ifdef INST_MEM_MISALIGN_CHK_EN
      r_mis_q    <= 1'b0;
      r_misalign <= 1'b0;
`endif
    end else begin
      r_data_ok <= w_respond;
      if (w_respond) begin
`ifdef INST_MEM_MISALIGN_CHK_EN
        r_inst <= w_rd_mis ? '0 : w_rd_word;
`else
        r_inst <= w_rd_word;
`endif
      end
`ifdef INST_MEM_MISALIGN_CHK_EN
      r_misalign <= w_respond && w_rd_mis;
`endif
      if (flush_i) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept && (Latency > 1)) begin
              r_addr_q <= instAddr_i;
              r_cnt    <= CNT_INIT;
              r_state  <= S_WAIT;
              r_busy   <= 1'b1;
`ifdef INST_MEM_MISALIGN_CHK_EN
              r_mis_q  <= (instAddr_i[1:0] != 2'b00);
`endif
            end
          end
          S_WAIT: begin
            if (r_cnt != 4'd0) begin
              r_cnt <= r_cnt - 4'd1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dataOk_o = r_data_ok;
  assign inst_o   = r_inst;
  assign busy_o   = r_busy;
`ifdef INST_MEM_MISALIGN_CHK_EN
  assign misalign_o = r_misalign;
`endif

endmodule

// File: tb/tb_inst_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_responder
//   Two responders share a preload bus: u_dut2 (Latency = 2) and u_dut3
//   (Latency = 3), each with its own request/flush inputs. Expected responses
//   (edge number, data, misalign flag) are queued when a request is driven
//   and matched by per-DUT monitors on the falling edge.
// ---------------------------------------------------------------------------
module tb_inst_mem_responder;

  typedef struct {
    int unsigned edge_n;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;

  logic        req2 = 1'b0, flush2 = 1'b0;
  logic [31:0] addr2 = '0;
  logic        ok2, busy2, mis2;
  logic [31:0] inst2;

  logic        req3 = 1'b0, flush3 = 1'b0;
  logic [31:0] addr3 = '0;
  logic        ok3, busy3, mis3;
  logic [31:0] inst3;

  int unsigned cyc = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;
  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  inst_mem_responder #(.Depth(1024), .Latency(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .request_i(req2), .instAddr_i(addr2),
    .flush_i(flush2), .memWe_i(we), .memWAddr_i(waddr), .memWData_i(wdata),
    .dataOk_o(ok2), .inst_o(inst2), .busy_o(busy2)
`ifdef INST_MEM_MISALIGN_CHK_EN
    , .misalign_o(mis2)
`endif
  );

  inst_mem_responder #(.Depth(1024), .Latency(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .request_i(req3), .instAddr_i(addr3),
    .flush_i(flush3), .memWe_i(we), .memWAddr_i(waddr), .memWData_i(wdata),
    .dataOk_o(ok3), .inst_o(inst3), .busy_o(busy3)
`ifdef INST_MEM_MISALIGN_CHK_EN
    , .misalign_o(mis3)
`endif
  );

`ifndef INST_MEM_MISALIGN_CHK_EN
  assign mis2 = 1'b0;
  assign mis3 = 1'b0;
`endif

  // Response monitors
  always @(negedge clk) begin
    exp_t e;
    if (q2.size() > 0 && q2[0].edge_n < cyc) begin
      tests++; fails++;
      $display("FAIL resp2_missing: no dataOk on edge %0d (expected data %h)", q2[0].edge_n, q2[0].data);
      void'(q2.pop_front());
    end
    if (ok2 === 1'b1) begin
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL resp2_unexpected: dataOk on edge %0d inst %h, expected no response", cyc, inst2);
      end else begin
        e = q2.pop_front();
        if (cyc !== e.edge_n || inst2 !== e.data || mis2 !== e.mis) begin
          fails++;
          $display("FAIL resp2: got edge %0d inst %h mis %b, expected edge %0d inst %h mis %b",
                   cyc, inst2, mis2, e.edge_n, e.data, e.mis);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q3.size() > 0 && q3[0].edge_n < cyc) begin
      tests++; fails++;
      $display("FAIL resp3_missing: no dataOk on edge %0d (expected data %h)", q3[0].edge_n, q3[0].data);
      void'(q3.pop_front());
    end
    if (ok3 === 1'b1) begin
      tests++;
      if (q3.size() == 0) begin
        fails++;
        $display("FAIL resp3_unexpected: dataOk on edge %0d inst %h, expected no response", cyc, inst3);
      end else begin
        e = q3.pop_front();
        if (cyc !== e.edge_n || inst3 !== e.data || mis3 !== e.mis) begin
          fails++;
          $display("FAIL resp3: got edge %0d inst %h mis %b, expected edge %0d inst %h mis %b",
                   cyc, inst3, mis3, e.edge_n, e.data, e.mis);
        end
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Single-cycle request pulse on DUT2; caller is at a falling edge with DUT2 idle.
  task automatic pulse2(input logic [31:0] a, input logic [31:0] d, input logic m);
    exp_t e;
    @(negedge clk);
    req2 = 1'b1; addr2 = a;
    e.edge_n = cyc + 2; e.data = d; e.mis = m;
    q2.push_back(e);
    @(negedge clk);
    req2 = 1'b0;
  endtask

  task automatic drain;
    repeat (7) @(negedge clk);
    tests++;
    if (q2.size() != 0 || q3.size() != 0) begin
      fails++;
      $display("FAIL drain: pending q2 %0d q3 %0d, expected 0 0", q2.size(), q3.size());
      q2.delete(); q3.delete();
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++;
    if (ok2 !== 1'b0 || inst2 !== 32'h0 || busy2 !== 1'b0 || mis2 !== 1'b0 ||
        ok3 !== 1'b0 || inst3 !== 32'h0 || busy3 !== 1'b0 || mis3 !== 1'b0) begin
      fails++;
      $display("FAIL reset_vals: got ok %b/%b inst %h/%h busy %b/%b mis %b/%b, expected all 0",
               ok2, ok3, inst2, inst3, busy2, busy3, mis2, mis3);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (ok2 !== 1'b0 || busy2 !== 1'b0 || ok3 !== 1'b0 || busy3 !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got ok %b/%b busy %b/%b, expected 0", ok2, ok3, busy2, busy3);
    end
  endtask

  task automatic test_single;
    preload(32'h40, 32'hDEADBEEF);
    pulse2(32'h40, 32'hDEADBEEF, 1'b0);
    tests++;
    if (busy2 !== 1'b1 || ok2 !== 1'b0) begin
      fails++;
      $display("FAIL single_wait: got busy %b ok %b, expected busy 1 ok 0", busy2, ok2);
    end
    @(negedge clk);
    tests++;
    if (busy2 !== 1'b0) begin
      fails++;
      $display("FAIL single_busy_len: got busy %b on response cycle, expected 0", busy2);
    end
    @(negedge clk);
    tests++;
    if (ok2 !== 1'b0 || inst2 !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single_hold: got ok %b inst %h, expected ok 0 inst deadbeef", ok2, inst2);
    end
    drain();
  endtask

  task automatic test_stream;
    exp_t e;
    preload(32'h0, 32'd1);
    preload(32'h4, 32'd2);
    preload(32'h8, 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req3 = 1'b1; addr3 = 32'(4 * i);
      e.edge_n = cyc + 3; e.data = 32'(i + 1); e.mis = 1'b0;
      q3.push_back(e);
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    req3 = 1'b0;
    drain();
  endtask

  task automatic test_flush;
    exp_t e;
    @(negedge clk);
    req2 = 1'b1; addr2 = 32'h0;
    @(negedge clk);
    flush2 = 1'b1;
    tests++;
    if (busy2 !== 1'b1) begin
      fails++;
      $display("FAIL flush_pre: got busy %b, expected 1", busy2);
    end
    @(negedge clk);
    flush2 = 1'b0;
    tests++;
    if (busy2 !== 1'b0 || ok2 !== 1'b0) begin
      fails++;
      $display("FAIL flush_cancel: got busy %b ok %b, expected 0 0", busy2, ok2);
    end
    e.edge_n = cyc + 2; e.data = 32'd1; e.mis = 1'b0;
    q2.push_back(e);
    @(negedge clk);
    req2 = 1'b0;
    tests++;
    if (busy2 !== 1'b1) begin
      fails++;
      $display("FAIL flush_reaccept: got busy %b, expected 1", busy2);
    end
    drain();
  endtask

  task automatic test_out_of_range;
    preload(32'hFFC, 32'hCAFEF00D);
    pulse2(32'h1000, 32'h0000_0013, 1'b0);
    drain();
    preload(32'h1000, 32'h12345678);
    pulse2(32'h0, 32'd1, 1'b0);
    drain();
    pulse2(32'hFFC, 32'hCAFEF00D, 1'b0);
    drain();
  endtask

  task automatic test_rw_collision;
    exp_t e;
    @(negedge clk);
    req2 = 1'b1; addr2 = 32'h8;
    e.edge_n = cyc + 2; e.data = 32'd3; e.mis = 1'b0;
    q2.push_back(e);
    @(negedge clk);
    req2 = 1'b0;
    we = 1'b1; waddr = 32'h8; wdata = 32'h55;
    @(negedge clk);
    we = 1'b0;
    drain();
    pulse2(32'h8, 32'h55, 1'b0);
    drain();
  endtask

  task automatic test_misalign;
`ifdef INST_MEM_MISALIGN_CHK_EN
    pulse2(32'h42, 32'h0, 1'b1);
`else
    pulse2(32'h42, 32'hDEADBEEF, 1'b0);
`endif
    drain();
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req3 = 1'b1; addr3 = 32'h4;
    @(negedge clk);
    req3 = 1'b0;
    tests++;
    if (busy3 !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_busy: got busy %b, expected 1", busy3);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (ok3 !== 1'b0 || inst3 !== 32'h0 || busy3 !== 1'b0 || inst2 !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_async: got ok %b inst %h busy %b inst2 %h, expected 0",
               ok3, inst3, busy3, inst2);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    drain();
    tests++;
    if (busy3 !== 1'b0 || inst3 !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_after: got busy %b inst %h, expected 0 0", busy3, inst3);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_flush();
    test_out_of_range();
    test_rw_collision();
    test_misalign();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
